vec_wb_scheduler: RTL and testbench

Writeback scheduler and register scoreboard for the vector CPU. Shares the single vector register-file write port (RegWriteW/wa3w/wd3) between the ALU pipeline and the memory load unit. Tracks in-flight destination registers so the decode stage stalls on RAW and WAW hazards. Sits between the execute/memory back ends and the Decode stage's register file.

---
 rtl/vec_wb_scheduler_if.sv | 62 ++++++
 rtl/vec_wb_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_vec_wb_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// vec_wb_scheduler_if
//
// Purpose: bundles the issue, writeback-request and register-file-write
// signals of the vector writeback scheduler.
//
// Signal groups (names follow the CPU datapath):
//   issue_*        decode -> scheduler issue request, issue_ready back
//   alu_* / mem_*  back-end writeback requests, *_ready grants back
//   RegWriteW, wa3w, wd3   registered register-file write port
//   stall_d        decode stall, sb_err sticky scoreboard error
//
// Modports:
//   master : the surrounding CPU (decode + back ends), drives requests
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface vec_wb_scheduler_if #(
  parameter int N = 16
);
  // Issue side
  logic                  issue_valid;
  logic                  issue_ready;
  logic                  issue_we;
  logic [3:0]            issue_wa;
  logic                  issue_use1;
  logic                  issue_use2;
  logic [3:0]            issue_ra1;
  logic [3:0]            issue_ra2;

  // Writeback requesters
  logic                  alu_valid;
  logic                  alu_ready;
  logic [3:0]            alu_wa;
  logic [15:0][N-1:0]    alu_wd;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [3:0]            mem_wa;
  logic [15:0][N-1:0]    mem_wd;

  // Register-file write port and status
  logic                  RegWriteW;
  logic [3:0]            wa3w;
  logic [15:0][N-1:0]    wd3;
  logic                  stall_d;
  logic                  sb_err;

  modport master (
    output issue_valid, issue_we, issue_wa, issue_use1, issue_use2,
           issue_ra1, issue_ra2,
           alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    input  issue_ready, alu_ready, mem_ready,
           RegWriteW, wa3w, wd3, stall_d, sb_err
  );

  modport slave (
    input  issue_valid, issue_we, issue_wa, issue_use1, issue_use2,
           issue_ra1, issue_ra2,
           alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    output issue_ready, alu_ready, mem_ready,
           RegWriteW, wa3w, wd3, stall_d, sb_err
  );
endinterface

// File: rtl/vec_wb_scheduler.sv
// ---------------------------------------------------------------------------
// vec_wb_scheduler
//
// Purpose: shares the single vector register-file write port between the ALU
// pipeline and the memory load unit, and keeps a per-register scoreboard of
// in-flight destinations so decode stalls on RAW and WAW hazards.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   RST   : asynchronous active-high reset
//   bus   : vec_wb_scheduler_if.slave (issue, writeback requests, RF write)
//
// Behaviour summary:
//   - pending bit sets on an issue fire with issue_we, clears on the edge that
//     ends the RegWriteW cycle for that register.
//   - one writeback grant per cycle; the grant registers RegWriteW/wa3w/wd3
//     for exactly one cycle (wa3w/wd3 hold afterwards).
//   - sb_err is sticky: a granted writeback found its register not pending.
//
// Configuration macro: VEC_WB_RR_EN
//   defined   : round-robin on a tie (the requester not granted last wins;
//               reset leaves "last = MEM" so ALU wins the first tie)
//   undefined : fixed priority, ALU over MEM
// ---------------------------------------------------------------------------
module vec_wb_scheduler #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  vec_wb_scheduler_if.slave    bus
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [15:0]          pending_q, pending_d;
  logic                 rwe_q, rwe_d;
  logic [3:0]           wa_q, wa_d;
  logic [15:0][N-1:0]   wd_q, wd_d;
  logic                 err_q, err_d;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  logic raw_hit;
  logic waw_hit;
  logic stall;
  logic issue_fire;

  assign raw_hit = (bus.issue_use1 & pending_q[bus.issue_ra1]) |
                   (bus.issue_use2 & pending_q[bus.issue_ra2]);
  assign waw_hit = bus.issue_we & pending_q[bus.issue_wa];
  assign stall   = bus.issue_valid & (raw_hit | waw_hit);

  // issue_ready is ~stall even with issue_valid low; fire still needs valid.
  assign issue_fire = bus.issue_valid & ~stall;

  assign bus.stall_d     = stall;
  assign bus.issue_ready = ~stall;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic alu_first;   // ALU wins a tie this cycle
  logic alu_gnt;
  logic mem_gnt;
  logic any_gnt;

`ifdef VEC_WB_RR_EN
  // Pointer remembers who won last; it only moves on an actual grant.
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } rr_state_e;

  rr_state_e rr_q, rr_d;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rr_q <= LAST_MEM;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign alu_first = (rr_q == LAST_MEM);

  always_comb begin
    rr_d = rr_q;
    if (alu_gnt) begin
      rr_d = LAST_ALU;
    end else if (mem_gnt) begin
      rr_d = LAST_MEM;
    end
  end
`else
  assign alu_first = 1'b1;
`endif

  assign alu_gnt = bus.alu_valid & (~bus.mem_valid | alu_first);
  assign mem_gnt = bus.mem_valid & ~alu_gnt;
  assign any_gnt = alu_gnt | mem_gnt;

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;

  // -------------------------------------------------------------------------
  // Granted writeback selection
  // -------------------------------------------------------------------------
  logic [3:0]         gnt_wa;
  logic [15:0][N-1:0] gnt_wd;

  assign gnt_wa = alu_gnt ? bus.alu_wa : bus.mem_wa;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign gnt_wd[gi] = alu_gnt ? bus.alu_wd[gi] : bus.mem_wd[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Scoreboard next state
  // -------------------------------------------------------------------------
  // Clear comes from the registered write currently on the RF port; set comes
  // from this cycle's issue. WAW stalling keeps them off the same register.
  logic [15:0] set_vec;
  logic [15:0] clr_vec;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_pend
      assign set_vec[gi] = issue_fire & bus.issue_we & (bus.issue_wa == 4'(gi));
      assign clr_vec[gi] = rwe_q & (wa_q == 4'(gi));
    end
  endgenerate

  always_comb begin
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // -------------------------------------------------------------------------
  // Write-port register and sticky error next state
  // -------------------------------------------------------------------------
  always_comb begin
    rwe_d = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    err_d = err_q;
    if (any_gnt) begin
      rwe_d = 1'b1;
      wa_d  = gnt_wa;
      wd_d  = gnt_wd;
      // Pending is sampled at grant time; the write still goes ahead.
      if (!pending_q[gnt_wa]) begin
        err_d = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pending_q <= '0;
      rwe_q     <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rwe_q     <= rwe_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  assign bus.RegWriteW = rwe_q;
  assign bus.wa3w      = wa_q;
  assign bus.wd3       = wd_q;
  assign bus.sb_err    = err_q;

endmodule

// File: tb/tb_vec_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vec_wb_scheduler
//
// Directed scenarios with literal expectations, followed by randomized issue
// and writeback traffic. A cycle-level behavioural model (scoreboard array,
// last-winner flag, write-port image) predicts every output each cycle.
// Build with +define+VEC_WB_RR_EN to exercise the round-robin variant.
// ---------------------------------------------------------------------------
module tb_vec_wb_scheduler;

  localparam int N = 16;

  logic clk = 1'b0;
  logic RST = 1'b1;

  vec_wb_scheduler_if #(.N(N)) ifc ();

  vec_wb_scheduler #(.N(N)) dut (
    .clk (clk),
    .RST (RST),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: state as seen after the most recent rising edge.
  // -------------------------------------------------------------------------
  bit           mp[16];
  bit           m_rwe;
  logic [3:0]   m_wa;
  logic [255:0] m_wd;
  bit           m_err;
  bit           m_last_mem;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mp[r] = 1'b0;
    m_rwe      = 1'b0;
    m_wa       = '0;
    m_wd       = '0;
    m_err      = 1'b0;
    m_last_mem = 1'b1;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit exp_stall, exp_ag, exp_mg, tie_alu;
    if (RST) model_reset();

    // Registered outputs against the model's current state.
    check("RegWriteW", 256'(ifc.RegWriteW), 256'(m_rwe));
    check("wa3w",      256'(ifc.wa3w),      256'(m_wa));
    check("wd3",       256'(ifc.wd3),       m_wd);
    check("sb_err",    256'(ifc.sb_err),    256'(m_err));

    // Hazard rule straight from the scoreboard array.
    exp_stall = ifc.issue_valid &&
                ((ifc.issue_use1 && mp[ifc.issue_ra1]) ||
                 (ifc.issue_use2 && mp[ifc.issue_ra2]) ||
                 (ifc.issue_we   && mp[ifc.issue_wa]));
`ifdef VEC_WB_RR_EN
    tie_alu = m_last_mem;
`else
    tie_alu = 1'b1;
`endif
    exp_ag = 1'b0;
    exp_mg = 1'b0;
    if (ifc.alu_valid && ifc.mem_valid) begin
      if (tie_alu) exp_ag = 1'b1; else exp_mg = 1'b1;
    end else if (ifc.alu_valid) begin
      exp_ag = 1'b1;
    end else if (ifc.mem_valid) begin
      exp_mg = 1'b1;
    end

    check("stall_d",     256'(ifc.stall_d),     256'(exp_stall));
    check("issue_ready", 256'(ifc.issue_ready), 256'(!exp_stall));
    check("alu_ready",   256'(ifc.alu_ready),   256'(exp_ag));
    check("mem_ready",   256'(ifc.mem_ready),   256'(exp_mg));

    if (!RST) begin
      // Advance to the state after the coming rising edge.
      bit           n_rwe;
      logic [3:0]   n_wa;
      logic [255:0] n_wd;
      n_rwe = 1'b0;
      n_wa  = m_wa;
      n_wd  = m_wd;
      if (exp_ag || exp_mg) begin
        n_rwe = 1'b1;
        n_wa  = exp_ag ? ifc.alu_wa : ifc.mem_wa;
        n_wd  = exp_ag ? 256'(ifc.alu_wd) : 256'(ifc.mem_wd);
        if (!mp[n_wa]) m_err = 1'b1;
        m_last_mem = exp_mg;
      end
      if (m_rwe) mp[m_wa] = 1'b0;
      if (ifc.issue_valid && !exp_stall && ifc.issue_we) mp[ifc.issue_wa] = 1'b1;
      m_rwe = n_rwe;
      m_wa  = n_wa;
      m_wd  = n_wd;
    end
  end

  // -------------------------------------------------------------------------
  // Driver helpers
  // -------------------------------------------------------------------------
  bit a_gnt_seen, m_gnt_seen;

  task automatic step();
    a_gnt_seen = ifc.alu_ready;
    m_gnt_seen = ifc.mem_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.issue_valid = 1'b0;
    ifc.issue_we    = 1'b0;
    ifc.issue_wa    = '0;
    ifc.issue_use1  = 1'b0;
    ifc.issue_use2  = 1'b0;
    ifc.issue_ra1   = '0;
    ifc.issue_ra2   = '0;
    ifc.alu_valid   = 1'b0;
    ifc.alu_wa      = '0;
    ifc.alu_wd      = '0;
    ifc.mem_valid   = 1'b0;
    ifc.mem_wa      = '0;
    ifc.mem_wd      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [3:0] wa,
                       input bit u1, input logic [3:0] r1,
                       input bit u2, input logic [3:0] r2);
    ifc.issue_valid = 1'b1;
    ifc.issue_we    = we;
    ifc.issue_wa    = wa;
    ifc.issue_use1  = u1;
    ifc.issue_ra1   = r1;
    ifc.issue_use2  = u2;
    ifc.issue_ra2   = r2;
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [3:0] pick_wa();
    logic [3:0] cand[$];
    for (int r = 0; r < 16; r++) if (mp[r]) cand.push_back(4'(r));
    if (cand.size() != 0 && $urandom_range(0, 9) != 0)
      return cand[$urandom_range(0, cand.size() - 1)];
    return 4'($urandom_range(0, 15));
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    bit alu_seq[4];
    bit mem_seq[4];
    clear_inputs();
    do_reset();

    // Reset values.
    check("rst_RegWriteW", 256'(ifc.RegWriteW), 256'(0));
    check("rst_sb_err",    256'(ifc.sb_err),    256'(0));
    check("rst_wd3",       256'(ifc.wd3),       256'(0));

    // 1: write to a non-pending register.
    ifc.alu_valid = 1'b1;
    ifc.alu_wa    = 4'd3;
    ifc.alu_wd    = {16{16'h00A5}};
    #1 check("t1_alu_ready", 256'(ifc.alu_ready), 256'(1));
    step();
    ifc.alu_valid = 1'b0;
    check("t1_RegWriteW", 256'(ifc.RegWriteW), 256'(1));
    check("t1_wa3w",      256'(ifc.wa3w),      256'(3));
    check("t1_wd3_lane0", 256'(ifc.wd3[0]),    256'(16'h00A5));
    check("t1_sb_err",    256'(ifc.sb_err),    256'(1));
    step();
    check("t1_RegWriteW_drop", 256'(ifc.RegWriteW), 256'(0));
    check("t1_wa3w_hold",      256'(ifc.wa3w),      256'(3));
    do_reset();

    // 2: RAW on register 5.
    issue(1, 4'd5, 0, 0, 0, 0);
    #1 check("t2_first_issue", 256'(ifc.issue_ready), 256'(1));
    step();
    issue(0, 0, 1, 4'd5, 0, 0);
    #1 check("t2_raw_stall", 256'(ifc.stall_d), 256'(1));
    step();
    ifc.alu_valid = 1'b1;
    ifc.alu_wa    = 4'd5;
    ifc.alu_wd    = 256'h5;
    #1 check("t2_stall_at_grant", 256'(ifc.stall_d), 256'(1));
    step();
    ifc.alu_valid = 1'b0;
    #1 check("t2_stall_during_write", 256'(ifc.stall_d), 256'(1));
    step();
    #1 check("t2_ready_t2", 256'(ifc.issue_ready), 256'(1));
    step();
    ifc.issue_valid = 1'b0;

    // 3: WAW on register 7.
    issue(1, 4'd7, 0, 0, 0, 0);
    step();
    issue(1, 4'd7, 0, 0, 0, 0);
    ifc.mem_valid = 1'b1;
    ifc.mem_wa    = 4'd7;
    ifc.mem_wd    = 256'h7;
    #1 check("t3_waw_stall", 256'(ifc.stall_d), 256'(1));
    check("t3_mem_ready", 256'(ifc.mem_ready), 256'(1));
    step();
    ifc.mem_valid = 1'b0;
    #1 check("t3_stall_during_write", 256'(ifc.stall_d), 256'(1));
    step();
    #1 check("t3_second_issue", 256'(ifc.issue_ready), 256'(1));
    step();
    issue(0, 0, 1, 4'd7, 0, 0);
    #1 check("t3_pending7_again", 256'(ifc.stall_d), 256'(1));
    ifc.issue_valid = 1'b0;
    do_reset();

    // 4: tie for four cycles.
    ifc.alu_valid = 1'b1;
    ifc.mem_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      alu_seq[c] = ifc.alu_ready;
      mem_seq[c] = ifc.mem_ready;
      step();
      ifc.alu_wa = 4'(c + 1);
      ifc.mem_wa = 4'(c + 8);
    end
    for (int c = 0; c < 4; c++) begin
`ifdef VEC_WB_RR_EN
      check($sformatf("t4_alu_gnt%0d", c), 256'(alu_seq[c]), 256'(c % 2 == 0));
      check($sformatf("t4_mem_gnt%0d", c), 256'(mem_seq[c]), 256'(c % 2 == 1));
`else
      check($sformatf("t4_alu_gnt%0d", c), 256'(alu_seq[c]), 256'(1));
      check($sformatf("t4_mem_gnt%0d", c), 256'(mem_seq[c]), 256'(0));
`endif
    end
    do_reset();

    // 5: reset during the write cycle of register 9.
    issue(1, 4'd9, 0, 0, 0, 0);
    step();
    ifc.issue_valid = 1'b0;
    ifc.alu_valid   = 1'b1;
    ifc.alu_wa      = 4'd9;
    ifc.alu_wd      = 256'h9;
    step();
    ifc.alu_valid = 1'b0;
    check("t5_write_cycle", 256'(ifc.RegWriteW), 256'(1));
    #2 RST = 1'b1;
    #1 check("t5_async_drop", 256'(ifc.RegWriteW), 256'(0));
    step();
    RST = 1'b0;
    issue(0, 0, 1, 4'd9, 0, 0);
    #1 check("t5_no_stall", 256'(ifc.stall_d), 256'(0));
    step();
    ifc.issue_valid = 1'b0;

    // 6: unrelated pending register does not stall.
    issue(1, 4'd4, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 1, 4'd2);
    #1 check("t6_no_stall", 256'(ifc.stall_d), 256'(0));
    check("t6_ready", 256'(ifc.issue_ready), 256'(1));
    step();
    do_reset();

    // Random traffic; the model process checks every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
        continue;
      end
      if (!ifc.alu_valid || a_gnt_seen) begin
        ifc.alu_valid = ($urandom_range(0, 1) == 1);
        ifc.alu_wa    = pick_wa();
        ifc.alu_wd    = rand_vec();
      end
      if (!ifc.mem_valid || m_gnt_seen) begin
        ifc.mem_valid = ($urandom_range(0, 2) == 0);
        ifc.mem_wa    = pick_wa();
        ifc.mem_wd    = rand_vec();
      end
      ifc.issue_valid = ($urandom_range(0, 3) != 0);
      ifc.issue_we    = ($urandom_range(0, 2) != 0);
      ifc.issue_wa    = 4'($urandom_range(0, 15));
      ifc.issue_use1  = $urandom_range(0, 1) == 1;
      ifc.issue_use2  = $urandom_range(0, 1) == 1;
      ifc.issue_ra1   = 4'($urandom_range(0, 15));
      ifc.issue_ra2   = 4'($urandom_range(0, 15));
      step();
    end

    clear_inputs();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
